imm_gen_pipe: RTL

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// imm_gen_pipe : two-stage RISC-V immediate generator with valid/ready flow
//                control, format decode and an illegal-opcode counter.
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module imm_gen_pipe #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [15:0]     illegal_cnt
);

  localparam logic [2:0]  c_FMT_NONE = 3'd0;
  localparam logic [2:0]  c_FMT_I    = 3'd1;
  localparam logic [2:0]  c_FMT_S    = 3'd2;
  localparam logic [2:0]  c_FMT_B    = 3'd3;
  localparam logic [2:0]  c_FMT_U    = 3'd4;
  localparam logic [2:0]  c_FMT_J    = 3'd5;
  localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;

  // Opcode bits are consumed by the decode, so S1 keeps only instr[31:7].
  logic            s1_valid_q, s1_valid_d;
  logic [31:7]     s1_instr_q, s1_instr_d;
  logic [2:0]      s1_fmt_q,   s1_fmt_d;
  logic            s2_valid_q, s2_valid_d;
  logic [XLEN-1:0] s2_imm_q,   s2_imm_d;
  logic [2:0]      s2_fmt_q,   s2_fmt_d;
  logic            s2_ill_q,   s2_ill_d;
  logic [15:0]     cnt_q,      cnt_d;

  logic            s1_ready_w;
  logic            s2_ready_w;
  logic [2:0]      dec_fmt_w;
  logic [31:0]     imm32_w;
  logic [XLEN-1:0] imm_ext_w;

  assign s2_ready_w = !s2_valid_q || out_ready;
  assign s1_ready_w = !s1_valid_q || s2_ready_w;

  // Outputs are forced quiet during reset so no transfer can complete then.
  assign in_ready    = s1_ready_w && !rst;
  assign out_valid   = s2_valid_q && !rst;
  assign out_imm     = rst ? '0 : s2_imm_q;
  assign out_fmt     = rst ? c_FMT_NONE : s2_fmt_q;
  assign out_illegal = s2_ill_q && !rst;
  assign illegal_cnt = rst ? 16'd0 : cnt_q;

  always_comb begin
    dec_fmt_w = c_FMT_NONE;
    case (in_instr[6:0])
      7'b0000011, 7'b0010011,
      7'b0011011, 7'b1100111: dec_fmt_w = c_FMT_I;
      7'b0100011:             dec_fmt_w = c_FMT_S;
      7'b1100011:             dec_fmt_w = c_FMT_B;
      7'b0110111, 7'b0010111: dec_fmt_w = c_FMT_U;
      7'b1101111:             dec_fmt_w = c_FMT_J;
      default:                dec_fmt_w = c_FMT_NONE;
    endcase
  end

  always_comb begin
    imm32_w = 32'd0;
    case (s1_fmt_q)
      c_FMT_I: imm32_w = {{20{s1_instr_q[31]}}, s1_instr_q[31:20]};
      c_FMT_S: imm32_w = {{20{s1_instr_q[31]}}, s1_instr_q[31:25], s1_instr_q[11:7]};
      c_FMT_B: imm32_w = {{20{s1_instr_q[31]}}, s1_instr_q[7], s1_instr_q[30:25],
                          s1_instr_q[11:8], 1'b0};
      c_FMT_U: imm32_w = {s1_instr_q[31:12], 12'd0};
      c_FMT_J: imm32_w = {{12{s1_instr_q[31]}}, s1_instr_q[19:12], s1_instr_q[20],
                          s1_instr_q[30:21], 1'b0};
      default: imm32_w = 32'd0;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_ext_wide
      assign imm_ext_w = {{(XLEN-32){imm32_w[31]}}, imm32_w};
    end else begin : g_ext_narrow
      assign imm_ext_w = imm32_w;
    end
  endgenerate

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_instr_d = s1_instr_q;
    s1_fmt_d   = s1_fmt_q;
    s2_valid_d = s2_valid_q;
    s2_imm_d   = s2_imm_q;
    s2_fmt_d   = s2_fmt_q;
    s2_ill_d   = s2_ill_q;
    cnt_d      = cnt_q;

    if (s1_ready_w) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_instr_d = in_instr[31:7];
        s1_fmt_d   = dec_fmt_w;
      end
    end

    if (s2_ready_w) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_imm_d = imm_ext_w;
        s2_fmt_d = s1_fmt_q;
        s2_ill_d = (s1_fmt_q == c_FMT_NONE);
      end
    end

    if (s2_valid_q && out_ready && s2_ill_q && (cnt_q != c_CNT_MAX))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_instr_q <= '0;
      s1_fmt_q   <= c_FMT_NONE;
      s2_valid_q <= 1'b0;
      s2_imm_q   <= '0;
      s2_fmt_q   <= c_FMT_NONE;
      s2_ill_q   <= 1'b0;
      cnt_q      <= 16'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_instr_q <= s1_instr_d;
      s1_fmt_q   <= s1_fmt_d;
      s2_valid_q <= s2_valid_d;
      s2_imm_q   <= s2_imm_d;
      s2_fmt_q   <= s2_fmt_d;
      s2_ill_q   <= s2_ill_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

`default_nettype wire
